// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports:
//   clk, arst_n               clock and asynchronous active-low reset
//   enable                    0 freezes all state; flush still acts
//   start, op                 new operation request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   operand_a, operand_b      rs / rt operands
//   flush                     abort the in-flight operation
//   busy                      high in RUN and FIX; the pipeline stalls on it
//   done                      one-cycle pulse when HI/LO take a new result
//   div_by_zero               valid with done; divide with operand_b == 0
//   hi, lo                    product halves, or remainder / quotient
module mdu_iterative #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic              is_div;
    logic              neg_p;
    logic              neg_r;
    logic              b_zero;
    logic [DATA_W-1:0] a_raw;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;

    // Signed ops work on magnitudes; -2^(W-1) maps to 2^(W-1),
    // which still fits an unsigned W-bit value.
    assign a_neg = op[0] & operand_a[DATA_W-1];
    assign b_neg = op[0] & operand_b[DATA_W-1];
    assign a_mag = a_neg ? -operand_a : operand_a;
    assign b_mag = b_neg ? -operand_b : operand_b;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;

    // Multiply: {acc_hi, acc_lo} holds partial product and the
    // not-yet-consumed multiplier bits; one right shift per step.
    assign mul_sum = {1'b0, acc_hi}
                   + ({1'b0, opnd} & {(DATA_W+1){acc_lo[0]}});

    // Divide: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out at the top and quotient bits in at the bottom.
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_p ? -prod : prod;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            a_raw       <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (enable) begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div      <= op[1];
                        neg_p       <= a_neg ^ b_neg;
                        neg_r       <= a_neg;
                        b_zero      <= op[1] & (operand_b == '0);
                        a_raw       <= operand_a;
                        opnd        <= op[1] ? b_mag : a_mag;
                        acc_hi      <= '0;
                        acc_lo      <= op[1] ? a_mag : b_mag;
                        count       <= LAST;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        if (!div_diff[DATA_W]) begin
                            acc_hi <= div_diff[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[DATA_W-1:0];
                            acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[DATA_W:1];
                        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    end
                    if (count == '0) begin
                        state <= S_FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                S_FIX: begin
                    if (b_zero) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        lo <= neg_p ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative with a result scoreboard.
// Ports: none (drives clk, arst_n and all DUT inputs).
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mdu_iterative #(.DATA_W(32)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [63:0] up;
        longint      sa;
        longint      sbv;
        longint      p;
        longint      q;
        longint      r;
        e = '0;
        case (o)
            2'b00: begin
                up   = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'b01: begin
                p    = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    sa   = longint'($signed(a));
                    sbv  = longint'($signed(b));
                    q    = sa / sbv;
                    r    = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge
    // right after the start edge (first RUN cycle).
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) scb.push_back(model(o, a, b));
    endtask

    // pre = negedges already spent (all busy) since issue returned.
    task automatic wait_done(input int lat_exp, input int busy_exp,
                             input int pre);
        int   n;
        int   busy_n;
        bit   got;
        exp_t e;
        n      = 0;
        got    = 1'b0;
        busy_n = pre + (busy ? 1 : 0);
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_n++;
        end
        if (!got) begin
            chk("done_timeout", 64'(n), 64'(lat_exp));
            return;
        end
        chk("latency", 64'(pre + n + 1), 64'(lat_exp));
        chk("busy_cycles", 64'(busy_n), 64'(busy_exp));
        if (scb.size() == 0) begin
            chk("scb_empty", 64'(1), 64'(0));
        end else begin
            e = scb.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("dbz", 64'(div_by_zero), 64'(e.dbz));
        end
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic quiet(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(0));
        chk({tag, "_lo"}, 64'(lo), 64'(0));
    endtask

    initial begin
        logic [31:0] h0;
        logic [31:0] l0;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // MULTU max * max
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(34, 33, 0);

        // MULT, with a start while busy that must be ignored
        issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b1);
        start     = 1'b1;
        op        = 2'b10;
        operand_a = 32'd1;
        operand_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(34, 33, 1);

        // back-to-back DIV -7 / 2
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(34, 33, 0);

        // divide by zero, then signed overflow
        issue(2'b10, 32'd100, 32'd0, 1'b1);
        wait_done(34, 33, 0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(34, 33, 0);

        // MULT -2^31 * -2^31
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(34, 33, 0);

        // flush in RUN cycle 10 of a MULTU
        h0 = hi;
        l0 = lo;
        issue(2'b00, 32'd5, 32'd6, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        quiet(40, "flush_no_done");
        chk("flush_hi", 64'(hi), 64'(h0));
        chk("flush_lo", 64'(lo), 64'(l0));
        issue(2'b10, 32'd9, 32'd4, 1'b1);
        wait_done(34, 33, 0);

        // enable low for 5 cycles mid-RUN
        h0 = hi;
        l0 = lo;
        issue(2'b01, 32'd12345, 32'hFFFF_FD5A, 1'b1);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        chk("freeze_hi", 64'(hi), 64'(h0));
        chk("freeze_lo", 64'(lo), 64'(l0));
        wait_done(39, 38, 10);

        // asynchronous reset at RUN cycle 12
        issue(2'b01, 32'd77, 32'hFFFF_FF00, 1'b0);
        repeat (11) @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'd7, 1'b1);
        wait_done(34, 33, 0);

        // random mix
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i[0]) rb = rb >> $urandom_range(0, 28);
            issue(ro, ra, rb, 1'b1);
            wait_done(34, 33, 0);
        end

        chk("scb_drained", 64'(scb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
